multi_digit_counter: RTL and testbench

//  Parametrised N-digit BCD counter with a built-in tick prescaler, parallel load and wrap flag.

---
 rtl/multi_digit_counter_pkg.sv | 19 +
 rtl/multi_digit_counter_bcd_digit.sv | 35 +++
 rtl/multi_digit_counter.sv | 72 +++++++
 tb/tb_multi_digit_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/multi_digit_counter_pkg.sv
// Shared constants and helpers for the N-digit BCD counter.
// Optional feature macro used by the top: MULTI_DIGIT_COUNTER_DOWN_EN.
package multi_digit_counter_pkg;

  localparam int          DIGIT_W    = 4;
  localparam int          MAX_DIGITS = 8;
  localparam logic [3:0]  BCD_MAX    = 4'd9;
  localparam logic [3:0]  BCD_ZERO   = 4'd0;

  // A prescaler of 1 or 2 still needs one state bit.
  function automatic int prescale_w(input int p);
    return (p <= 2) ? 1 : $clog2(p);
  endfunction

  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/multi_digit_counter_bcd_digit.sv
// One BCD digit: synchronous reset, saturating parallel load, up/down step gated by the carry chain.
// Direction is supplied by the top (forced to up unless MULTI_DIGIT_COUNTER_DOWN_EN is defined).
module bcd_digit
  import multi_digit_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               carry_in,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_nibble,
  output logic [DIGIT_W-1:0] nibble,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] r_nibble;
  logic [DIGIT_W-1:0] w_next;

  always_comb begin
    w_next = r_nibble;
    if (dir) w_next = (r_nibble == BCD_ZERO) ? BCD_MAX  : r_nibble - 4'd1;
    else     w_next = (r_nibble == BCD_MAX)  ? BCD_ZERO : r_nibble + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)                   r_nibble <= BCD_ZERO;
    else if (load)             r_nibble <= bcd_sat(load_nibble);
    else if (step && carry_in) r_nibble <= w_next;
  end

  assign nibble    = r_nibble;
  assign carry_out = carry_in & (dir ? (r_nibble == BCD_ZERO) : (r_nibble == BCD_MAX));

endmodule

// File: rtl/multi_digit_counter.sv
// N-digit BCD counter with tick prescaler, parallel load and wrap pulse.
// Define MULTI_DIGIT_COUNTER_DOWN_EN to honour the dir input (down counting); otherwise up-only.
module multi_digit_counter
  import multi_digit_counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int PRESCALE = 4
) (
  input  logic                  multi_digit_counter_clk,
  input  logic                  multi_digit_counter_rst,
  input  logic                  multi_digit_counter_clk_rst,
  input  logic                  multi_digit_counter_en,
  input  logic                  multi_digit_counter_load,
  input  logic [4*DIGITS-1:0]   multi_digit_counter_load_val,
  input  logic                  multi_digit_counter_dir,
  output logic [4*DIGITS-1:0]   multi_digit_counter_digits,
  output logic                  multi_digit_counter_tick,
  output logic                  multi_digit_counter_wrap
);

  localparam int                PRE_W    = prescale_w(PRESCALE);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
`ifdef MULTI_DIGIT_COUNTER_DOWN_EN
  localparam bit                DOWN_EN  = 1'b1;
`else
  localparam bit                DOWN_EN  = 1'b0;
`endif

  logic [PRE_W-1:0] r_pre;
  logic             r_tick;
  logic             r_wrap;
  logic             w_dir;
  logic             w_step_raw;
  logic             w_step;
  logic [DIGITS:0]  w_carry;

  assign w_dir      = DOWN_EN & multi_digit_counter_dir;
  assign w_step_raw = multi_digit_counter_en & (r_pre == PRE_LAST);
  // Load and clk_rst both suppress a coincident step; rst reaches the digits directly.
  assign w_step     = w_step_raw & ~multi_digit_counter_load & ~multi_digit_counter_clk_rst;
  assign w_carry[0] = 1'b1;

  always_ff @(posedge multi_digit_counter_clk) begin
    if (multi_digit_counter_rst || multi_digit_counter_load || multi_digit_counter_clk_rst) begin
      r_pre  <= '0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      if (multi_digit_counter_en) r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
      r_tick <= w_step_raw;
      r_wrap <= w_step_raw & w_carry[DIGITS];
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk         (multi_digit_counter_clk),
      .rst         (multi_digit_counter_rst),
      .step        (w_step),
      .carry_in    (w_carry[gi]),
      .dir         (w_dir),
      .load        (multi_digit_counter_load),
      .load_nibble (multi_digit_counter_load_val[4*gi +: 4]),
      .nibble      (multi_digit_counter_digits[4*gi +: 4]),
      .carry_out   (w_carry[gi+1])
    );
  end

  assign multi_digit_counter_tick = r_tick;
  assign multi_digit_counter_wrap = r_wrap;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench: 2-digit / prescale-4 instance plus a 3-digit / prescale-1 instance.
module tb_multi_digit_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0, clk_rst = 1'b0, en = 1'b0, load = 1'b0, dir = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] digits;
  logic       tick, wrap;

  logic        b_rst = 1'b0, b_clk_rst = 1'b0, b_en = 1'b0, b_load = 1'b0, b_dir = 1'b0;
  logic [11:0] b_load_val = 12'h000;
  logic [11:0] b_digits;
  logic        b_tick, b_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_digit_counter #(.DIGITS(2), .PRESCALE(4)) u_dut (
    .multi_digit_counter_clk      (clk),
    .multi_digit_counter_rst      (rst),
    .multi_digit_counter_clk_rst  (clk_rst),
    .multi_digit_counter_en       (en),
    .multi_digit_counter_load     (load),
    .multi_digit_counter_load_val (load_val),
    .multi_digit_counter_dir      (dir),
    .multi_digit_counter_digits   (digits),
    .multi_digit_counter_tick     (tick),
    .multi_digit_counter_wrap     (wrap)
  );

  multi_digit_counter #(.DIGITS(3), .PRESCALE(1)) u_dut_b (
    .multi_digit_counter_clk      (clk),
    .multi_digit_counter_rst      (b_rst),
    .multi_digit_counter_clk_rst  (b_clk_rst),
    .multi_digit_counter_en       (b_en),
    .multi_digit_counter_load     (b_load),
    .multi_digit_counter_load_val (b_load_val),
    .multi_digit_counter_dir      (b_dir),
    .multi_digit_counter_digits   (b_digits),
    .multi_digit_counter_tick     (b_tick),
    .multi_digit_counter_wrap     (b_wrap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic t, input logic w);
    check({tag, ".digits"}, 32'(digits), 32'(d));
    check({tag, ".tick"},   32'(tick),   32'(t));
    check({tag, ".wrap"},   32'(wrap),   32'(w));
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  initial begin
    // 1: reset, then 40 enabled cycles
    rst = 1'b1; b_rst = 1'b1;
    cyc(1);
    chk_out("reset", 8'h00, 1'b0, 1'b0);
    check("reset_b.digits", 32'(b_digits), 32'h000);
    rst = 1'b0; b_rst = 1'b0; en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      check("run.tick",   32'(tick),   32'((k % 4) == 0));
      check("run.digits", 32'(digits), 32'(bcd2(k / 4)));
    end
    check("run.end", 32'(digits), 32'h10);

    // 2: load 98, wrap through 99 -> 00
    load = 1'b1; load_val = 8'h98;
    cyc(1);
    load = 1'b0;
    chk_out("load98", 8'h98, 1'b0, 1'b0);
    cyc(4);
    chk_out("to99", 8'h99, 1'b1, 1'b0);
    cyc(4);
    chk_out("wrap00", 8'h00, 1'b1, 1'b1);
    cyc(1);
    chk_out("wrap_clear", 8'h00, 1'b0, 1'b0);

    // 3: saturating load, then load colliding with a wrapping step
    load = 1'b1; load_val = 8'hF3;
    cyc(1);
    chk_out("loadF3", 8'h93, 1'b0, 1'b0);
    load_val = 8'h99;
    cyc(1);
    load = 1'b0;
    cyc(3);
    load = 1'b1; load_val = 8'h42;
    cyc(1);
    load = 1'b0;
    chk_out("load_wins", 8'h42, 1'b0, 1'b0);

    // 4: en low holds prescaler phase, then clk_rst restarts it
    cyc(2);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk_out("hold", 8'h42, 1'b0, 1'b0);
    end
    en = 1'b1;
    cyc(1);
    check("resume1.tick", 32'(tick), 32'h0);
    cyc(1);
    chk_out("resume2", 8'h43, 1'b1, 1'b0);
    cyc(1);
    clk_rst = 1'b1;
    cyc(1);
    clk_rst = 1'b0;
    chk_out("clk_rst", 8'h43, 1'b0, 1'b0);
    cyc(3);
    check("after_clk_rst3.tick", 32'(tick), 32'h0);
    cyc(1);
    chk_out("after_clk_rst4", 8'h44, 1'b1, 1'b0);
    cyc(3);
    clk_rst = 1'b1;
    cyc(1);
    clk_rst = 1'b0;
    chk_out("clk_rst_suppress", 8'h44, 1'b0, 1'b0);

    // 5: reset mid-count
    load = 1'b1; load_val = 8'h57;
    cyc(1);
    load = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk_out("mid_rst", 8'h00, 1'b0, 1'b0);
    cyc(3);
    check("mid_rst3.tick", 32'(tick), 32'h0);
    cyc(1);
    chk_out("mid_rst4", 8'h01, 1'b1, 1'b0);

    // 6: direction from 00
    load = 1'b1; load_val = 8'h00;
    cyc(1);
    load = 1'b0; dir = 1'b1;
    cyc(4);
`ifdef MULTI_DIGIT_COUNTER_DOWN_EN
    chk_out("down_wrap", 8'h99, 1'b1, 1'b1);
    cyc(4);
    chk_out("down_98", 8'h98, 1'b1, 1'b0);
`else
    chk_out("dir_ignored", 8'h01, 1'b1, 1'b0);
`endif
    dir = 1'b0;

    // 3-digit, prescale 1: 999 -> 000 with wrap, continuous tick
    b_load = 1'b1; b_load_val = 12'h999;
    cyc(1);
    b_load = 1'b0; b_en = 1'b1;
    check("b_load.digits", 32'(b_digits), 32'h999);
    cyc(1);
    check("b_wrap.digits", 32'(b_digits), 32'h000);
    check("b_wrap.wrap",   32'(b_wrap),   32'h1);
    check("b_wrap.tick",   32'(b_tick),   32'h1);
    cyc(1);
    check("b_next.digits", 32'(b_digits), 32'h001);
    check("b_next.wrap",   32'(b_wrap),   32'h0);
    check("b_next.tick",   32'(b_tick),   32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
